// File: rtl/iir_coeff_bank.sv
// iir_coeff_bank
//   Double-buffered, runtime-loadable coefficient store for the cascaded
//   biquad IIR datapath. Writes land in the shadow bank; a commit request
//   swaps shadow and active banks at the next datapath sample boundary.
//   After the swap, the new active bank is copied into the new shadow bank,
//   one stage per cycle, so that both banks hold the same contents again.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   wr_valid/ready    coefficient write handshake (ready only while idle)
//   wr_stage, wr_sel  write target: stage index, coefficient 0=b0..4=a2
//   wr_data           coefficient value
//   commit_req        request a shadow->active swap
//   swap_allow        datapath is at a sample boundary; a swap may happen
//   rd_stage          stage index to read from the active bank
//   b0,b1,b2,a1,a2    registered active-bank coefficients for rd_stage
//   bank_sel          physical bank currently active
//   swap_done         one-cycle pulse on the cycle after a swap
//   busy              swap pending or shadow copy in progress
//   err               sticky flag for writes to a nonexistent stage/select
module iir_coeff_bank #(
    parameter int COEF_W    = 16,
    parameter int FRAC_BITS = 14,
    parameter int N_STAGES  = 6,
    parameter int IDX_W     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [IDX_W-1:0]  wr_stage,
    input  logic [2:0]        wr_sel,
    input  logic [COEF_W-1:0] wr_data,
    input  logic              commit_req,
    input  logic              swap_allow,
    input  logic [IDX_W-1:0]  rd_stage,
    output logic [COEF_W-1:0] b0,
    output logic [COEF_W-1:0] b1,
    output logic [COEF_W-1:0] b2,
    output logic [COEF_W-1:0] a1,
    output logic [COEF_W-1:0] a2,
    output logic              bank_sel,
    output logic              swap_done,
    output logic              busy,
    output logic              err
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PENDING = 2'd1;
    localparam logic [1:0] COPY    = 2'd2;

    localparam logic [COEF_W-1:0] UNITY   = {{(COEF_W-1){1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [IDX_W:0]    N_ST    = N_STAGES[IDX_W:0];
    localparam logic [IDX_W-1:0]  LAST_ST = N_ST[IDX_W-1:0] - 1'b1;

    logic [1:0]        state;
    logic [IDX_W-1:0]  copy_idx;
    logic [COEF_W-1:0] mem [2][N_STAGES][5];
    logic              wr_legal;
    logic              rd_legal;

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign wr_legal = ({1'b0, wr_stage} < N_ST) && (wr_sel <= 3'd4);
    assign rd_legal = ({1'b0, rd_stage} < N_ST);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned bk = 0; bk < 2; bk++) begin
                for (int unsigned st = 0; st < N_STAGES; st++) begin
                    mem[bk][st][0] <= UNITY;
                    for (int unsigned k = 1; k < 5; k++) begin
                        mem[bk][st][k] <= '0;
                    end
                end
            end
            b0        <= UNITY;
            b1        <= '0;
            b2        <= '0;
            a1        <= '0;
            a2        <= '0;
            bank_sel  <= 1'b0;
            swap_done <= 1'b0;
            err       <= 1'b0;
            state     <= IDLE;
            copy_idx  <= '0;
        end else begin
            swap_done <= 1'b0;

            // Uses the pre-edge bank_sel, so a read sampled at the swap edge
            // still returns the old bank.
            if (rd_legal) begin
                b0 <= mem[bank_sel][rd_stage][0];
                b1 <= mem[bank_sel][rd_stage][1];
                b2 <= mem[bank_sel][rd_stage][2];
                a1 <= mem[bank_sel][rd_stage][3];
                a2 <= mem[bank_sel][rd_stage][4];
            end else begin
                b0 <= UNITY;
                b1 <= '0;
                b2 <= '0;
                a1 <= '0;
                a2 <= '0;
            end

            case (state)
                IDLE: begin
                    if (wr_valid) begin
                        if (wr_legal) begin
                            mem[~bank_sel][wr_stage][wr_sel] <= wr_data;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    if (commit_req) begin
                        state <= PENDING;
                    end
                end
                PENDING: begin
                    if (swap_allow) begin
                        bank_sel  <= ~bank_sel;
                        swap_done <= 1'b1;
                        copy_idx  <= '0;
                        state     <= COPY;
                    end
                end
                COPY: begin
                    // bank_sel already names the new active bank here.
                    for (int unsigned k = 0; k < 5; k++) begin
                        mem[~bank_sel][copy_idx][k] <= mem[bank_sel][copy_idx][k];
                    end
                    if (copy_idx == LAST_ST) begin
                        copy_idx <= '0;
                        state    <= IDLE;
                    end else begin
                        copy_idx <= copy_idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
